// File: rtl/ro_worker_sequencer_pkg.sv
// ro_worker_sequencer_pkg: shared states, byte order and default timing for the worker sequencer
package ro_worker_sequencer_pkg;
  localparam int SHIFT_HI_DEF = 8;
  localparam int SHIFT_LO_DEF = 8;
  localparam int RST_CYCLES_DEF = 4;
  localparam int EW_DEF = 24;
  localparam logic [1:0] B_START_HI = 2'd0;
  localparam logic [1:0] B_START_LO = 2'd1;
  localparam logic [1:0] B_LIMIT_HI = 2'd2;
  localparam logic [1:0] B_LIMIT_LO = 2'd3;
  typedef enum logic [3:0] {
    S_IDLE, S_WRST, S_LOAD_LO, S_LOAD_HI, S_RUN, S_STOP_HI, S_CAPTURE, S_RECOVER, S_RESULT
  } state_t;
  function automatic logic [7:0] job_byte(input logic [15:0] s, input logic [15:0] l, input logic [1:0] k);
    return k == B_START_HI ? s[15:8] : k == B_START_LO ? s[7:0] : k == B_LIMIT_HI ? l[15:8] : l[7:0];
  endfunction
endpackage

// File: rtl/ro_worker_sequencer_if.sv
// ro_worker_sequencer_if: job, result and worker pin bundle; master is the environment, slave the sequencer
interface ro_worker_sequencer_if
  import ro_worker_sequencer_pkg::*;
#(
  parameter int EW = EW_DEF
);
  logic          job_valid;
  logic          job_ready;
  logic          job_mode;
  logic          job_clock_sel;
  logic [15:0]   job_start;
  logic [15:0]   job_limit;
  logic [EW-1:0] job_stop_after;
  logic          res_valid;
  logic          res_ready;
  logic [EW-1:0] res_elapsed;
  logic [7:0]    res_byte;
  logic          res_timeout;
  logic [7:0]    w_din;
  logic          w_shift;
  logic          w_mode;
  logic          w_stop;
  logic          w_clock_sel;
  logic          w_rst_n;
  logic          w_done_async;
  logic [7:0]    w_result;
  logic          busy;
  modport master (
    output job_valid, job_mode, job_clock_sel, job_start, job_limit, job_stop_after, res_ready,
           w_done_async, w_result,
    input  job_ready, res_valid, res_elapsed, res_byte, res_timeout, w_din, w_shift, w_mode,
           w_stop, w_clock_sel, w_rst_n, busy
  );
  modport slave (
    input  job_valid, job_mode, job_clock_sel, job_start, job_limit, job_stop_after, res_ready,
           w_done_async, w_result,
    output job_ready, res_valid, res_elapsed, res_byte, res_timeout, w_din, w_shift, w_mode,
           w_stop, w_clock_sel, w_rst_n, busy
  );
endinterface

// File: rtl/ro_worker_sequencer_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  assign o_q = r_q;
  // Two back-to-back flops give the first stage a full cycle to resolve
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_q <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q <= r_meta;
    end
  end
endmodule

// File: rtl/ro_worker_sequencer.sv
// ro_worker_sequencer: runs one ring-oscillator worker job: reset, byte load, timed run, optional stop, capture
module ro_worker_sequencer
  import ro_worker_sequencer_pkg::*;
#(
  parameter int SHIFT_HI = SHIFT_HI_DEF,
  parameter int SHIFT_LO = SHIFT_LO_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int EW = EW_DEF
) (
  input logic clk,
  input logic reset,
  ro_worker_sequencer_if.slave bus
);
  localparam logic [15:0] C_HI = 16'(SHIFT_HI - 1);
  localparam logic [15:0] C_LO = 16'(SHIFT_LO - 1);
  localparam logic [15:0] C_RST = 16'(RST_CYCLES - 1);
  state_t        r_state;
  logic [15:0]   r_cnt;
  logic [1:0]    r_k;
  logic [15:0]   r_start;
  logic [15:0]   r_limit;
  logic [EW-1:0] r_stop_after;
  logic [EW-1:0] r_elapsed;
  logic          r_fired;
  logic          r_job_ready;
  logic          r_res_valid;
  logic [7:0]    r_res_byte;
  logic          r_res_timeout;
  logic [7:0]    r_din;
  logic          r_shift;
  logic          r_mode;
  logic          r_stop;
  logic          r_clock_sel;
  logic          r_rst_n;
  logic          r_busy;
  logic          w_done;
  logic          w_cnt_zero;
  logic          w_el_max;
  logic [EW-1:0] w_el_inc;
  sync2 u_sync (.clk(clk), .reset(reset), .i_d(bus.w_done_async), .o_q(w_done));
  assign w_cnt_zero = r_cnt == '0;
  assign w_el_max = r_elapsed == {EW{1'b1}};
  assign w_el_inc = w_el_max ? r_elapsed : r_elapsed + EW'(1);
  assign bus.job_ready = r_job_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_elapsed = r_elapsed;
  assign bus.res_byte = r_res_byte;
  assign bus.res_timeout = r_res_timeout;
  assign bus.w_din = r_din;
  assign bus.w_shift = r_shift;
  assign bus.w_mode = r_mode;
  assign bus.w_stop = r_stop;
  assign bus.w_clock_sel = r_clock_sel;
  assign bus.w_rst_n = r_rst_n;
  assign bus.busy = r_busy;
  // Job FSM; the shared down-counter times every wait and idles at zero, and the
  // stop is launched one cycle early so w_stop is high in the cycle elapsed equals stop_after
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_k <= '0;
      r_start <= '0;
      r_limit <= '0;
      r_stop_after <= '0;
      r_elapsed <= '0;
      r_fired <= 1'b0;
      r_job_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_byte <= '0;
      r_res_timeout <= 1'b0;
      r_din <= '0;
      r_shift <= 1'b0;
      r_mode <= 1'b0;
      r_stop <= 1'b0;
      r_clock_sel <= 1'b0;
      r_rst_n <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      if (!w_cnt_zero) r_cnt <= r_cnt - 16'd1;
      case (r_state)
        S_IDLE: begin
          r_job_ready <= 1'b1;
          r_rst_n <= 1'b1;
          r_busy <= 1'b0;
          if (bus.job_valid && r_job_ready) begin
            r_start <= bus.job_start;
            r_limit <= bus.job_limit;
            r_stop_after <= bus.job_stop_after;
            r_mode <= bus.job_mode;
            r_clock_sel <= bus.job_clock_sel;
            r_k <= '0;
            r_fired <= 1'b0;
            r_res_timeout <= 1'b0;
            r_res_byte <= '0;
            r_job_ready <= 1'b0;
            r_busy <= 1'b1;
            r_rst_n <= 1'b0;
            r_cnt <= C_RST;
            r_state <= S_WRST;
          end
        end
        S_WRST: if (w_cnt_zero) begin
          r_rst_n <= 1'b1;
          r_din <= job_byte(r_start, r_limit, r_k);
          r_cnt <= C_LO;
          r_state <= S_LOAD_LO;
        end
        S_LOAD_LO: if (w_cnt_zero) begin
          r_shift <= 1'b1;
          r_cnt <= C_HI;
          r_state <= S_LOAD_HI;
        end
        S_LOAD_HI: if (w_cnt_zero) begin
          r_shift <= 1'b0;
          if (r_k == B_LIMIT_LO) begin
            r_elapsed <= '0;
            if (r_mode && r_stop_after == '0) begin
              r_stop <= 1'b1;
              r_fired <= 1'b1;
              r_cnt <= C_HI;
              r_state <= S_STOP_HI;
            end else r_state <= S_RUN;
          end else begin
            r_k <= r_k + 2'd1;
            r_din <= job_byte(r_start, r_limit, r_k + 2'd1);
            r_cnt <= C_LO;
            r_state <= S_LOAD_LO;
          end
        end
        S_RUN: begin
          if (w_done) begin
            r_cnt <= C_LO;
            r_state <= S_CAPTURE;
          end else if (w_el_max) begin
            r_res_timeout <= 1'b1;
            r_res_byte <= '0;
            r_rst_n <= 1'b0;
            r_cnt <= C_RST;
            r_state <= S_RECOVER;
          end else begin
            r_elapsed <= r_elapsed + EW'(1);
            if (r_mode && !r_fired && r_elapsed + EW'(1) == r_stop_after) begin
              r_stop <= 1'b1;
              r_fired <= 1'b1;
              r_cnt <= C_HI;
              r_state <= S_STOP_HI;
            end
          end
        end
        S_STOP_HI: begin
          r_elapsed <= w_el_inc;
          if (w_cnt_zero) begin
            r_stop <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_CAPTURE: if (w_cnt_zero) begin
          r_res_byte <= bus.w_result;
          r_res_valid <= 1'b1;
          r_state <= S_RESULT;
        end
        S_RECOVER: if (w_cnt_zero) begin
          r_rst_n <= 1'b1;
          r_res_valid <= 1'b1;
          r_state <= S_RESULT;
        end
        S_RESULT: if (bus.res_ready) begin
          r_res_valid <= 1'b0;
          r_job_ready <= 1'b1;
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ro_worker_sequencer.sv
// tb_ro_worker_sequencer: timeline-model bench for the worker sequencer (24-bit and 8-bit elapsed instances)
module tb_ro_worker_sequencer;
  localparam int RST = 4;
  localparam int LO = 8;
  localparam int HI = 8;
  localparam int PER = LO + HI;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic jv = 1'b0;
  logic rr = 1'b0;
  logic done = 1'b0;
  logic jm = 1'b0;
  logic jc = 1'b0;
  logic [15:0] js = '0;
  logic [15:0] jl = '0;
  logic [23:0] jsa = '0;
  int ncmp = 0;
  int nfail = 0;
  ro_worker_sequencer_if #(.EW(24)) b24 ();
  ro_worker_sequencer_if #(.EW(8)) b8 ();
  ro_worker_sequencer #(.SHIFT_HI(HI), .SHIFT_LO(LO), .RST_CYCLES(RST), .EW(24)) u24 (.clk(clk), .reset(reset), .bus(b24));
  ro_worker_sequencer #(.SHIFT_HI(HI), .SHIFT_LO(LO), .RST_CYCLES(RST), .EW(8)) u8 (.clk(clk), .reset(reset), .bus(b8));
  always #5 clk = ~clk;
  assign b24.job_valid = jv & !sel;
  assign b8.job_valid = jv & sel;
  assign b24.res_ready = rr & !sel;
  assign b8.res_ready = rr & sel;
  assign b24.w_done_async = done & !sel;
  assign b8.w_done_async = done & sel;
  assign b24.job_mode = jm;
  assign b8.job_mode = jm;
  assign b24.job_clock_sel = jc;
  assign b8.job_clock_sel = jc;
  assign b24.job_start = js;
  assign b8.job_start = js;
  assign b24.job_limit = jl;
  assign b8.job_limit = jl;
  assign b24.job_stop_after = jsa;
  assign b8.job_stop_after = jsa[7:0];
  // Worker models: shift register loaded on each w_shift rise, cleared by w_rst_n
  logic [31:0] sr24, sr8;
  logic wp24, wp8;
  always @(posedge clk) begin
    wp24 <= b24.w_shift;
    wp8 <= b8.w_shift;
    if (!b24.w_rst_n) sr24 <= '0;
    else if (b24.w_shift && !wp24) sr24 <= {sr24[23:0], b24.w_din};
    if (!b8.w_rst_n) sr8 <= '0;
    else if (b8.w_shift && !wp8) sr8 <= {sr8[23:0], b8.w_din};
  end
  assign b24.w_result = sr24[31:24] ^ sr24[23:16] ^ sr24[15:8] ^ sr24[7:0];
  assign b8.w_result = sr8[31:24] ^ sr8[23:16] ^ sr8[15:8] ^ sr8[7:0];
  logic o_ready, o_valid, o_rst_n, o_busy, o_shift, o_stop, o_mode, o_csel, o_tmo;
  logic [7:0] o_din, o_byte;
  logic [23:0] o_el;
  assign o_ready = sel ? b8.job_ready : b24.job_ready;
  assign o_valid = sel ? b8.res_valid : b24.res_valid;
  assign o_rst_n = sel ? b8.w_rst_n : b24.w_rst_n;
  assign o_busy = sel ? b8.busy : b24.busy;
  assign o_shift = sel ? b8.w_shift : b24.w_shift;
  assign o_stop = sel ? b8.w_stop : b24.w_stop;
  assign o_mode = sel ? b8.w_mode : b24.w_mode;
  assign o_csel = sel ? b8.w_clock_sel : b24.w_clock_sel;
  assign o_tmo = sel ? b8.res_timeout : b24.res_timeout;
  assign o_din = sel ? b8.w_din : b24.w_din;
  assign o_byte = sel ? b8.res_byte : b24.res_byte;
  assign o_el = sel ? {16'd0, b8.res_elapsed} : b24.res_elapsed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One job from acceptance to handshake; dt < 0 means the worker never reports done.
  // Entered and left at a negedge with the selected sequencer idle.
  task automatic run_job(input logic mode, input logic csel, input logic [15:0] start, input logic [15:0] limit,
                         input int sa, input int dt, input int hold);
    logic [7:0] b [4];
    int r0, e, tv, emax, ln;
    bit tmo, fires, rst_exp;
    logic [7:0] xb;
    b = '{start[15:8], start[7:0], limit[15:8], limit[7:0]};
    xb = b[0] ^ b[1] ^ b[2] ^ b[3];
    r0 = RST + 4 * PER;
    emax = sel ? 255 : 24'hFFFFFF;
    tmo = dt < 0;
    e = tmo ? emax : dt + 2;
    if (!tmo && mode && e >= sa && e < sa + HI) e = sa + HI;
    fires = mode && !tmo && dt + 2 >= sa;
    tv = tmo ? r0 + e + RST + 1 : r0 + e + LO + 1;
    chk("job_ready_idle", o_ready, 1);
    jm = mode; jc = csel; js = start; jl = limit; jsa = 24'(sa); jv = 1'b1;
    for (int t = 0; t <= tv + hold; t++) begin
      @(negedge clk);
      if (t == 0) begin jv = 1'b0; done = 1'b0; end
      if (!tmo && t == r0 + dt) done = 1'b1;
      rst_exp = !(t < RST || (tmo && t > r0 + e && t <= r0 + e + RST));
      chk("w_rst_n", o_rst_n, rst_exp);
      chk("busy", o_busy, 1);
      chk("job_ready_busy", o_ready, 0);
      chk("res_valid", o_valid, t >= tv);
      chk("w_mode", o_mode, mode);
      chk("w_clock_sel", o_csel, csel);
      if (t >= RST && t < r0) begin
        ln = t - RST;
        chk("w_shift_load", o_shift, (ln % PER) >= LO);
        chk("w_din", o_din, b[ln / PER]);
      end else chk("w_shift_idle", o_shift, 0);
      chk("w_stop", o_stop, fires && t >= r0 + sa && t < r0 + sa + HI);
      if (t >= tv) begin
        chk("res_elapsed", o_el, e);
        chk("res_byte", o_byte, tmo ? 8'h00 : xb);
        chk("res_timeout", o_tmo, tmo);
      end
      if (t == tv + hold) rr = 1'b1;
    end
    @(negedge clk);
    rr = 1'b0;
    chk("res_valid_after", o_valid, 0);
    chk("job_ready_after", o_ready, 1);
    chk("busy_after", o_busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_job_ready", b24.job_ready, 0);
    chk("rst_w_rst_n", b24.w_rst_n, 0);
    chk("rst_busy", b24.busy, 0);
    chk("rst_res_valid", b24.res_valid, 0);
    chk("rst_w_shift", b24.w_shift, 0);
    chk("rst_w_stop", b24.w_stop, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_job_ready", b24.job_ready, 1);
    chk("post_rst_w_rst_n", b24.w_rst_n, 1);
    run_job(1'b0, 1'b1, 16'h0010, 16'h0020, 0, 100, 0);
    run_job(1'b1, 1'b1, 16'h1234, 16'h5678, 50, 60, 0);
    run_job(1'b0, 1'b0, 16'(32'($urandom)), 16'(32'($urandom)), 0, $urandom_range(0, 60), 20);
    run_job(1'b1, 1'b0, 16'hA5C3, 16'h0F0F, 0, 20, 1);
    run_job(1'b1, 1'b1, 16'h00FF, 16'hFF00, 5, 3, 0);
    for (int i = 0; i < 5; i++)
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'(32'($urandom)), 16'(32'($urandom)),
              $urandom_range(0, 80), $urandom_range(0, 120), $urandom_range(0, 3));
    sel = 1'b1;
    run_job(1'b0, 1'b1, 16'hBEEF, 16'hC0DE, 0, -1, 2);
    sel = 1'b0;
    chk("rml_job_ready", o_ready, 1);
    js = 16'h1357; jl = 16'h2468; jm = 1'b0; jc = 1'b0; jsa = '0; jv = 1'b1;
    for (int t = 0; t <= RST + 2 * PER + LO + 2; t++) begin
      @(negedge clk);
      if (t == 0) jv = 1'b0;
    end
    chk("rml_in_third_hi", o_shift, 1);
    chk("rml_third_din", o_din, 8'h24);
    reset = 1'b1;
    @(negedge clk);
    chk("rml_w_shift", o_shift, 0);
    chk("rml_w_rst_n", o_rst_n, 0);
    chk("rml_busy", o_busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rml_job_ready_after", o_ready, 1);
    chk("rml_w_rst_n_after", o_rst_n, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
